// File: rtl/usb_tx_encoder_if.sv
// Signal bundle between the USB transmit encoder and its packet/shift-register
// neighbours. The master side drives the packet start and the serial data bit.
// The slave side is the encoder, which returns the strobes, status and line pair.
interface usb_tx_encoder_if;
  logic tx_start;
  logic tx_bit;
  logic data_end;
  logic shift_strobe;
  logic byte_done;
  logic busy;
  logic tx_done;
  logic d_plus;
  logic d_minus;

  modport master (
    output tx_start, tx_bit, data_end,
    input  shift_strobe, byte_done, busy, tx_done, d_plus, d_minus
  );

  modport slave (
    input  tx_start, tx_bit, data_end,
    output shift_strobe, byte_done, busy, tx_done, d_plus, d_minus
  );
endinterface

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder.
// It pulls one bit per bit period from the upstream shift register, then applies
// bit stuffing and NRZI, drives D+/D-, and finishes each packet with SE0,SE0,J.
// shift_strobe and byte_done are combinational in the boundary cycle, so the
// shift register advances on the same edge that this block consumes tx_bit.
module usb_tx_encoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int STUFF_LEN    = 6
) (
  input  logic            clk,
  input  logic            n_rst,
  usb_tx_encoder_if.slave bus
);

  localparam int PW = $clog2(CLKS_PER_BIT);
  localparam int OW = $clog2(STUFF_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACTIVE  = 2'd1,
    S_EOP_SE0 = 2'd2,
    S_EOP_J   = 2'd3
  } state_t;

  state_t          r_state;
  logic [PW-1:0]   r_period;
  logic [OW-1:0]   r_ones;
  logic [2:0]      r_bitcnt;
  logic            r_eop_cnt;
  logic            r_dp;
  logic            r_dm;
  logic            r_busy;
  logic            r_tx_done;

  state_t          w_state_nxt;
  logic [PW-1:0]   w_period_nxt;
  logic [OW-1:0]   w_ones_nxt;
  logic [2:0]      w_bitcnt_nxt;
  logic            w_eop_nxt;
  logic            w_dp_nxt;
  logic            w_dm_nxt;
  logic            w_busy_nxt;
  logic            w_done_nxt;
  logic            w_strobe;
  logic            w_byte_done;

  logic            w_start;
  logic            w_boundary;
  logic            w_decide;
  logic [OW-1:0]   w_ones_cur;
  logic [2:0]      w_bit_cur;
  logic            w_cur_dp;
  logic            w_cur_dm;

  // A start is accepted only from IDLE and never while reset is asserted.
  // That start cycle is itself the first bit boundary.
  assign w_start    = (r_state == S_IDLE) && bus.tx_start && n_rst;
  assign w_boundary = w_start || ((r_state != S_IDLE) && (r_period == '0));
  assign w_decide   = w_start || ((r_state == S_ACTIVE) && w_boundary);

  // Counters are treated as already cleared in the start cycle so that the first bit uses fresh values.
  assign w_ones_cur = w_start ? '0 : r_ones;
  assign w_bit_cur  = w_start ? 3'd0 : r_bitcnt;
  assign w_cur_dp   = (r_state == S_IDLE) ? 1'b1 : r_dp;
  assign w_cur_dm   = (r_state == S_IDLE) ? 1'b0 : r_dm;

  // Next-state, counter and line decisions taken at each bit boundary.
  always_comb begin
    w_state_nxt  = r_state;
    w_period_nxt = r_period;
    w_ones_nxt   = r_ones;
    w_bitcnt_nxt = r_bitcnt;
    w_eop_nxt    = r_eop_cnt;
    w_dp_nxt     = w_cur_dp;
    w_dm_nxt     = w_cur_dm;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_strobe     = 1'b0;
    w_byte_done  = 1'b0;

    if (w_decide) begin
      w_state_nxt = S_ACTIVE;
      w_busy_nxt  = 1'b1;
      if (w_ones_cur == OW'(STUFF_LEN)) begin
        // Stuffed zero: toggle the line, do not consume a data bit.
        w_dp_nxt     = ~w_cur_dp;
        w_dm_nxt     = ~w_cur_dm;
        w_ones_nxt   = '0;
        w_bitcnt_nxt = w_bit_cur;
      end else if (bus.data_end) begin
        w_dp_nxt     = 1'b0;
        w_dm_nxt     = 1'b0;
        w_state_nxt  = S_EOP_SE0;
        w_eop_nxt    = 1'b0;
        w_ones_nxt   = w_ones_cur;
        w_bitcnt_nxt = w_bit_cur;
      end else begin
        w_strobe     = 1'b1;
        w_byte_done  = (w_bit_cur == 3'd7);
        w_bitcnt_nxt = w_bit_cur + 3'd1;
        if (bus.tx_bit) begin
          w_ones_nxt = w_ones_cur + OW'(1);
        end else begin
          w_ones_nxt = '0;
          w_dp_nxt   = ~w_cur_dp;
          w_dm_nxt   = ~w_cur_dm;
        end
      end
    end else begin
      case (r_state)
        S_EOP_SE0: begin
          if (w_boundary) begin
            if (r_eop_cnt) begin
              w_dp_nxt    = 1'b1;
              w_dm_nxt    = 1'b0;
              w_eop_nxt   = 1'b0;
              w_state_nxt = S_EOP_J;
            end else begin
              w_eop_nxt = 1'b1;
            end
          end else begin
            w_eop_nxt = r_eop_cnt;
          end
        end
        S_EOP_J: begin
          if (w_boundary) begin
            w_state_nxt = S_IDLE;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_busy_nxt = 1'b1;
          end
        end
        S_IDLE: begin
          w_busy_nxt = 1'b0;
        end
        S_ACTIVE: begin
          w_busy_nxt = 1'b1;
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end

    // The period counter free-runs while a packet is in flight and sits at zero in IDLE.
    if (w_state_nxt == S_IDLE) begin
      w_period_nxt = '0;
    end else if (r_period == PW'(CLKS_PER_BIT - 1)) begin
      w_period_nxt = '0;
    end else begin
      w_period_nxt = r_period + PW'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters and registered line and status outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_period  <= '0;
      r_ones    <= '0;
      r_bitcnt  <= 3'd0;
      r_eop_cnt <= 1'b0;
      r_dp      <= 1'b1;
      r_dm      <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
    end else begin
      r_period  <= w_period_nxt;
      r_ones    <= w_ones_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_eop_cnt <= w_eop_nxt;
      r_dp      <= w_dp_nxt;
      r_dm      <= w_dm_nxt;
      r_busy    <= w_busy_nxt;
      r_tx_done <= w_done_nxt;
    end
  end

  assign bus.shift_strobe = w_strobe;
  assign bus.byte_done    = w_byte_done;
  assign bus.busy         = r_busy;
  assign bus.tx_done      = r_tx_done;
  assign bus.d_plus       = r_dp;
  assign bus.d_minus      = r_dm;

endmodule
